// File: rtl/uart_stream_pkg.sv
// uart_stream_pkg: FSM state, framing constants and size
// helpers shared by the sample streamer and its sub-blocks.
package uart_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_HI,
    WAIT_LO
  } tx_state_e;

  localparam logic [7:0] HDR0_DEF = 8'h43;
  localparam logic [7:0] HDR1_DEF = 8'h48;
  localparam logic [7:0] ID_BASE  = 8'h30;

  function automatic int bytes_per(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int frame_len(input int w, input int n);
    return 4 + n * (1 + bytes_per(w));
  endfunction

endpackage

// File: rtl/strobe_decim.sv
// strobe_decim: sample_clk rising-edge detect with enable gating
// and a DECIM edge counter. Ports: clk, rst_n, enable, sample_clk in; trig out.
module strobe_decim #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sample_clk,
  output logic trig
);

  localparam logic [15:0] TOP = 16'(DECIM - 1);

  logic        sclk_q;
  logic [15:0] cnt;
  logic        rise;
  logic        wrap;

  assign rise = sample_clk & ~sclk_q;
  assign wrap = cnt == TOP;
  assign trig = enable & rise & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sclk_q <= sample_clk;
      // Disabled: hold at 0 so re-enable needs DECIM fresh edges.
      if (!enable) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= wrap ? '0 : cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_sample_streamer.sv
// uart_sample_streamer: atomically snapshots N signed W-bit channels
// on a decimated sample_clk edge and sends each as a framed packet
// (hdr, seq, id+sample bytes, xor checksum) over the uart_tx byte port.
// Ports: clk, rst_n, enable, sample_clk, samples in; tx_start, tx_data
// out, tx_busy in; frame_strobe, overrun_count status out.
module uart_sample_streamer
  import uart_stream_pkg::*;
#(
  parameter int         W     = 16,
  parameter int         N     = 4,
  parameter int         DECIM = 1,
  parameter logic [7:0] HDR0  = HDR0_DEF,
  parameter logic [7:0] HDR1  = HDR1_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           sample_clk,
  input  logic [N*W-1:0] samples,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic           frame_strobe,
  output logic [7:0]     overrun_count
);

  localparam int         B       = bytes_per(W);
  localparam int         LEN     = frame_len(W, N);
  localparam logic [7:0] LAST    = 8'(LEN - 1);
  localparam logic [2:0] SUB_TOP = 3'(B);
  localparam logic [4:0] CH_TOP  = 5'(N - 1);

  tx_state_e      state;
  tx_state_e      state_n;
  logic           trig;
  logic           accept;
  logic           drop;
  logic           last;
  logic           body;
  logic           advance;
  logic [7:0]     idx;
  logic [7:0]     seq;
  logic [7:0]     seq_cur;
  logic [7:0]     csum;
  logic [7:0]     data_q;
  logic [7:0]     cur_byte;
  logic [4:0]     ch;
  logic [2:0]     sub;
  logic [N*W-1:0] snap;
  logic [W-1:0]   samp;
  logic [31:0]    ext;
  logic [7:0]     sel;

  strobe_decim #(
    .DECIM(DECIM)
  ) u_decim (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sample_clk(sample_clk),
    .trig      (trig)
  );

  assign accept  = trig && state == IDLE;
  assign drop    = trig && state != IDLE;
  assign last    = idx == LAST;
  assign body    = idx > 8'd2 && !last;
  assign advance = state == WAIT_LO && !tx_busy && !last;

  // sub = 0 is the channel id byte, 1..B walk the sample MSB first.
  assign samp = snap[int'(ch)*W +: W];
  assign ext  = 32'($signed(samp));
  assign sel  = 8'(ext >> (8 * (B - int'(sub))));

  always_comb begin
    cur_byte = 8'h00;
    unique case (1'b1)
      idx == 8'd0:             cur_byte = HDR0;
      idx == 8'd1:             cur_byte = HDR1;
      idx == 8'd2:             cur_byte = seq_cur;
      last:                    cur_byte = csum;
      body && sub == 3'd0:     cur_byte = ID_BASE + 8'(ch);
      body && sub != 3'd0:     cur_byte = sel;
      default:                 cur_byte = 8'h00;
    endcase
  end

  assign tx_data = tx_start ? cur_byte : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    tx_start     = 1'b0;
    frame_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) state_n = LOAD;
      end
      // Hold off while uart_tx is still busy from elsewhere.
      LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_n      = last ? IDLE : LOAD;
          frame_strobe = last;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap          <= '0;
      seq           <= '0;
      seq_cur       <= '0;
      csum          <= '0;
      data_q        <= '0;
      idx           <= '0;
      ch            <= '0;
      sub           <= '0;
      overrun_count <= '0;
    end else begin
      if (accept) begin
        snap    <= samples;
        seq_cur <= seq;
        seq     <= seq + 8'd1;
        csum    <= '0;
        idx     <= '0;
        ch      <= '0;
        sub     <= '0;
      end
      if (tx_start) begin
        data_q <= cur_byte;
        if (idx >= 8'd2 && !last) csum <= csum ^ cur_byte;
      end
      if (advance) begin
        idx <= idx + 8'd1;
        if (idx >= 8'd3) begin
          if (sub == SUB_TOP) begin
            sub <= '0;
            // Parking on the last channel keeps the slice in range.
            if (ch != CH_TOP) ch <= ch + 5'd1;
          end else begin
            sub <= sub + 3'd1;
          end
        end
      end
      if (drop && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_streamer.sv
// tb_uart_sample_streamer: directed bench for uart_sample_streamer,
// three instances (16x4, 12x1, 16x4 decim 3) each with a uart_tx model.
module tb_uart_sample_streamer;

  typedef struct {
    logic [63:0]  smp;
    logic [127:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        en_a, sclk_a, start_a, busy_a, strobe_a;
  logic [63:0] smp_a;
  logic [7:0]  data_a, ovr_a;
  logic        en_b, sclk_b, start_b, busy_b, strobe_b;
  logic [11:0] smp_b;
  logic [7:0]  data_b, ovr_b;
  logic        en_c, sclk_c, start_c, busy_c, strobe_c;
  logic [63:0] smp_c;
  logic [7:0]  data_c, ovr_c;

  int compared = 0;
  int mismatched = 0;

  int cnt_a, cnt_b, cnt_c;
  int fs_a = 0, fs_b = 0, fs_c = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_sample_streamer #(.W(16), .N(4), .DECIM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .sample_clk(sclk_a),
    .samples(smp_a), .tx_start(start_a), .tx_data(data_a),
    .tx_busy(busy_a), .frame_strobe(strobe_a), .overrun_count(ovr_a)
  );

  uart_sample_streamer #(.W(12), .N(1), .DECIM(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .sample_clk(sclk_b),
    .samples(smp_b), .tx_start(start_b), .tx_data(data_b),
    .tx_busy(busy_b), .frame_strobe(strobe_b), .overrun_count(ovr_b)
  );

  uart_sample_streamer #(.W(16), .N(4), .DECIM(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .sample_clk(sclk_c),
    .samples(smp_c), .tx_start(start_c), .tx_data(data_c),
    .tx_busy(busy_c), .frame_strobe(strobe_c), .overrun_count(ovr_c)
  );

  // uart_tx models: busy for 10 cycles after each accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
    end else begin
      if (start_a && cnt_a == 0) cnt_a <= 10;
      else if (cnt_a != 0) cnt_a <= cnt_a - 1;
      if (start_b && cnt_b == 0) cnt_b <= 10;
      else if (cnt_b != 0) cnt_b <= cnt_b - 1;
      if (start_c && cnt_c == 0) cnt_c <= 10;
      else if (cnt_c != 0) cnt_c <= cnt_c - 1;
    end
  end

  assign busy_a = cnt_a != 0;
  assign busy_b = cnt_b != 0;
  assign busy_c = cnt_c != 0;

  always @(posedge clk) begin
    if (rst_n && start_a) q_a.push_back(data_a);
    if (rst_n && start_b) q_b.push_back(data_b);
    if (rst_n && start_c) q_c.push_back(data_c);
    if (rst_n && strobe_a) fs_a++;
    if (rst_n && strobe_b) fs_b++;
    if (rst_n && strobe_c) fs_c++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    if (which == 0) sclk_a = 1'b1;
    else if (which == 1) sclk_b = 1'b1;
    else sclk_c = 1'b1;
    tick(2);
    sclk_a = 1'b0;
    sclk_b = 1'b0;
    sclk_c = 1'b0;
  endtask

  function automatic int fs_of(input int which);
    return which == 0 ? fs_a : which == 1 ? fs_b : fs_c;
  endfunction

  function automatic int qsize(input int which);
    return which == 0 ? q_a.size() : which == 1 ? q_b.size() : q_c.size();
  endfunction

  function automatic logic [7:0] qbyte(input int which, input int k);
    if (k >= qsize(which)) return 8'hxx;
    return which == 0 ? q_a[k] : which == 1 ? q_b[k] : q_c[k];
  endfunction

  task automatic wait_fs(input int which, input int target, input string name);
    int n;
    n = 0;
    while (fs_of(which) < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, fs_of(which), target);
  endtask

  task automatic cmp_frame(input int which, input int base, input int len,
                           input logic [127:0] exp, input string name);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s byte%0d", name, i), qbyte(which, base + i),
            exp[127 - 8*i -: 8]);
    end
  endtask

  initial begin
    int base, f0, n, want;
    vec_t vecs [3];

    vecs[0].smp = 64'h0001_8000_FFFF_1234;
    vecs[0].exp = 128'h43480030_123431FF_FF328000_330001A7;
    vecs[1].smp = 64'hABCD_00FF_7FFF_0000;
    vecs[1].exp = 128'h43480130_0000317F_FF3200FF_33ABCD18;
    vecs[2].smp = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].exp = 128'h43480230_FFFF31FF_FF32FFFF_33FFFF02;

    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    sclk_a = 1'b0; sclk_b = 1'b0; sclk_c = 1'b0;
    smp_a = '0; smp_b = '0; smp_c = '0;
    tick(3);
    check("rst tx_start", start_a, 0);
    check("rst tx_data", data_a, 0);
    check("rst frame_strobe", strobe_a, 0);
    check("rst overrun", ovr_a, 0);
    check("rst tx_start_b", start_b, 0);
    check("rst tx_start_c", start_c, 0);
    rst_n = 1'b1;
    tick(2);

    // Table: full frames, samples scrambled right after the trigger.
    for (int v = 0; v < 3; v++) begin
      base = qsize(0);
      f0 = fs_a;
      smp_a = vecs[v].smp;
      pulse(0);
      smp_a = 64'h5A5A_A5A5_5A5A_A5A5;
      wait_fs(0, f0 + 1, $sformatf("vec%0d strobe", v));
      cmp_frame(0, base, 16, vecs[v].exp, $sformatf("vec%0d", v));
      tick(3);
    end
    check("table overrun", ovr_a, 0);

    // Reset while byte 5 is being loaded.
    base = qsize(0);
    smp_a = vecs[0].smp;
    pulse(0);
    n = 0;
    while (!(qsize(0) == base + 4 && start_a) && n < 500) begin
      tick(1);
      n++;
    end
    check("byte5 load seen", start_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid rst tx_start", start_a, 0);
    check("mid rst tx_data", data_a, 0);
    check("mid rst strobe", strobe_a, 0);
    check("mid rst overrun", ovr_a, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base = qsize(0);
    f0 = fs_a;
    pulse(0);
    wait_fs(0, f0 + 1, "post rst strobe");
    cmp_frame(0, base, 16, vecs[0].exp, "post rst");
    tick(3);

    // Edges every 50 cycles against ~192-cycle frames: 1 in 4 accepted.
    base = qsize(0);
    smp_a = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int e = 0; e < 344; e++) begin
      pulse(0);
      if (e == 0) smp_a = 64'h0;
      tick(48);
      if (e == 7) check("overrun after 8 edges", ovr_a, 6);
      if (e == 339) check("overrun reaches 255", ovr_a, 255);
    end
    tick(250);
    check("overrun saturated", ovr_a, 255);
    cmp_frame(0, base, 16, 128'h43480130_FFFF31FF_FF32FFFF_33FFFF01,
              "inflight");

    // 12-bit single channel, negative full scale.
    base = qsize(1);
    f0 = fs_b;
    smp_b = 12'h800;
    pulse(1);
    smp_b = 12'h123;
    wait_fs(1, f0 + 1, "w12 strobe");
    cmp_frame(1, base, 7, {56'h43480030F800C8, 72'h0}, "w12");

    // DECIM = 3: frames start after edges 3 and 6 only.
    base = qsize(2);
    f0 = fs_c;
    for (int k = 1; k <= 7; k++) begin
      pulse(2);
      tick(3);
      want = (k % 3 == 0) ? 16 * (k / 3 - 1) + 1 : 16 * (k / 3);
      check($sformatf("decim edge%0d bytes", k), qsize(2) - base, want);
      tick(245);
    end
    check("decim frames", fs_of(2) - f0, 2);

    // Enable dropped mid-frame; counter sits at 1 after 7 edges.
    base = qsize(2);
    f0 = fs_c;
    smp_c = vecs[0].smp;
    pulse(2);
    tick(10);
    pulse(2);
    tick(3);
    check("edge9 starts frame", qsize(2) - base, 1);
    tick(40);
    en_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse(2);
      tick(20);
    end
    wait_fs(2, f0 + 1, "disabled frame strobe");
    cmp_frame(2, base, 16, 128'h43480230_123431FF_FF328000_330001A5,
              "disabled");
    for (int k = 0; k < 2; k++) begin
      pulse(2);
      tick(60);
    end
    check("no frame while disabled", qsize(2) - base, 16);
    check("no overrun while disabled", ovr_c, 0);
    en_c = 1'b1;
    tick(2);
    for (int k = 1; k <= 3; k++) begin
      pulse(2);
      tick(3);
      want = (k == 3) ? 17 : 16;
      check($sformatf("reenable edge%0d bytes", k), qsize(2) - base, want);
      tick(20);
    end
    wait_fs(2, f0 + 2, "reenable strobe");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
